// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexes four hex digits onto a common-anode display with anti-ghost blanking and blink.
module seven_seg_scanner #(
    parameter int BLANK_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLK_1KHz,
    input  logic        CLK_2Hz,
    input  logic        ENABLE,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLINK,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FRAME
);
    logic        clk1k_q, blink_q, live, tick, wrap, blink_n, live_n, lit;
    logic [1:0]  sel, sel_n;
    logic [16:0] cnt, cnt_n;
    logic [15:0] sh_dig, sh_dig_n;
    logic [3:0]  sh_dp, sh_dp_n, sh_bl, sh_bl_n, nib;
    logic [6:0]  dec;

    always_comb begin
        tick     = ENABLE & CLK_1KHz & ~clk1k_q;
        wrap     = tick & (sel == 2'd3);
        sel_n    = tick ? sel + 2'd1 : sel;
        cnt_n    = tick ? 17'(BLANK_CYCLES) : (ENABLE && |cnt) ? cnt - 17'd1 : cnt;
        blink_n  = tick ? CLK_2Hz : blink_q;
        live_n   = live | tick;
        sh_dig_n = wrap ? DIGITS : sh_dig;
        sh_dp_n  = wrap ? DP_IN : sh_dp;
        sh_bl_n  = wrap ? BLINK : sh_bl;
        nib      = sh_dig_n[{sel_n, 2'b00} +: 4];
        lit      = ENABLE & live_n & ~|cnt_n & ~(sh_bl_n[sel_n] & blink_n);
    end

    always_comb begin
        dec = 7'h7F;
        case (nib)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            4'hF: dec = 7'h0E;
            default: dec = 7'h7F;
        endcase
    end

    // outputs are registered from next-state values so a digit lights the cycle its counter reaches zero
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk1k_q <= 1'b0;
            blink_q <= 1'b0;
            live    <= 1'b0;
            sel     <= 2'd3;
            cnt     <= '0;
            sh_dig  <= '0;
            sh_dp   <= '0;
            sh_bl   <= '0;
            AN      <= 4'hF;
            SEG     <= 7'h7F;
            DP      <= 1'b1;
            FRAME   <= 1'b0;
        end else begin
            clk1k_q <= CLK_1KHz;
            blink_q <= blink_n;
            live    <= live_n;
            sel     <= sel_n;
            cnt     <= cnt_n;
            sh_dig  <= sh_dig_n;
            sh_dp   <= sh_dp_n;
            sh_bl   <= sh_bl_n;
            AN      <= lit ? ~(4'b0001 << sel_n) : 4'hF;
            SEG     <= lit ? dec : 7'h7F;
            DP      <= lit ? ~sh_dp_n[sel_n] : 1'b1;
            FRAME   <= wrap;
        end
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Drives the board's 4-digit, common-anode seven-segment display that shows elevator floor and status.
- Sits directly downstream of the frequency divider and runs entirely on the 100 MHz system clock.
- Treats the divider's CLK_1KHz and CLK_2Hz outputs as data levels. It edge-detects CLK_1KHz to time digit scanning and samples CLK_2Hz as the blink phase. Neither signal is ever used as a clock.

Parameters:
- BLANK_CYCLES, default 64: system-clock cycles that all anodes stay off after each digit switch (anti-ghosting). Legal range 0..99999.

Ports:
- CLK  input  1  100 MHz system clock.
- RST  input  1  synchronous reset, active-high.
- CLK_1KHz  input  1  square wave from the divider; its rising edge is the scan tick.
- CLK_2Hz  input  1  square wave from the divider; high level = blink-off phase.
- ENABLE  input  1  0 = display dark, scanning frozen.
- DIGITS  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- DP_IN  input  4  per-digit decimal point request, active-high.
- BLINK  input  4  per-digit blink enable.
- AN  output  4  anode enables, active-low; AN[i] = digit i.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- FRAME  output  1  one-cycle pulse when scanning wraps to digit 0.

Behaviour:
- Reset (RST=1 at a CLK edge), applied on the next edge, including mid-scan:
  - AN=4'b1111, SEG=7'h7F, DP=1, FRAME=0.
  - Digit select sel=3, shadow register=16'h0000, DP/blink shadows=0, blank counter=0, clk1k_q=0, blink_q=0.
- Tick: tick = CLK_1KHz & ~clk1k_q, with clk1k_q registered every cycle. A tick is one CLK cycle long per rising edge of CLK_1KHz. Ticks are detected only while ENABLE=1.
- On each tick:
  - sel advances (3 wraps to 0).
  - Blank counter loads BLANK_CYCLES.
  - blink_q samples CLK_2Hz.
- Wrap to 0 (sel 3 -> 0):
  - DIGITS, DP_IN and BLINK are captured into shadow registers in the same cycle.
  - FRAME pulses high for exactly that cycle.
  - All four digits of a frame come from one coherent snapshot. Input changes mid-frame appear only at the next frame.
- First tick after reset selects digit 0 and pulses FRAME. The display stays dark from reset until that tick.
- Output timing (registered; outputs update on the edge after the tick):
  - While the blank counter is nonzero: AN=4'b1111, SEG=7'h7F, DP=1. The counter decrements by 1 per cycle.
  - Once it reaches 0: AN has only bit sel low, SEG = decode(shadow nibble sel), DP = ~shadow_dp[sel].
  - BLANK_CYCLES=0 means the digit is lit on the cycle after the tick.
- Blink: if shadow_blink[sel]=1 and blink_q=1, that slot stays fully dark (AN, SEG and DP all off) for the whole slot.
- ENABLE=0: outputs go dark on the next edge; sel, shadows and counter hold. When ENABLE returns to 1, the first subsequent tick resumes from sel+1.
- Tick while the blank counter is still nonzero: the counter reloads (restarts) and sel still advances.
- Decode table (hex in -> SEG):
  - 0->40, 1->79, 2->24, 3->30
  - 4->19, 5->12, 6->02, 7->78
  - 8->00, 9->10, A->08, b->03
  - C->46, d->21, E->06, F->0E
- Scan rate: 1 ms per digit, 4 ms frame (250 Hz refresh).

Test Plan:
Test bench settings for all scenarios: BLANK_CYCLES=4; CLK_1KHz driven as a 40-CLK-period square wave; CLK_2Hz held 0 unless stated.
- Reset then DIGITS=16'h1234, ENABLE=1:
  - First CLK_1KHz rise -> FRAME pulse, 4 dark cycles, then AN=4'b1110 and SEG=7'h19 ("4").
  - Following slots -> AN=1101/SEG=30, AN=1011/SEG=24, AN=0111/SEG=79, then FRAME again.
- DIGITS changes 1234->ABCD while sel=1 -> slots 2 and 3 still show "2" and "1". The next frame shows D,C,b,A (SEG=21,46,03,08).
- BLINK=4'b0001, DP_IN=4'b0100:
  - CLK_2Hz=1 at a digit-0 tick -> that slot fully dark.
  - CLK_2Hz=0 -> digit 0 lit.
  - Digit 2 always shows DP=0.
- ENABLE dropped to 0 for 100 cycles during digit 1 -> AN=1111 on the next edge and no FRAME pulses. After re-enable, the next tick shows digit 2.
- RST asserted for 1 cycle mid-slot -> AN=1111, SEG=7F, DP=1 on the next edge. The next tick pulses FRAME and shows digit 0.
- All 16 values cycled through digit 0 -> SEG matches the decode table exactly.
